// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Runs one address-phase + data-phase transaction on the multiplexed A/D bus
// of the external RTC chip per start request, with programmable strobe pulse
// and hold widths. Read data is latched at the end of the data strobe.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_start             single-cycle request, sampled only in IDLE
//   i_wr                1 = write, 0 = read (captured with i_start)
//   i_addr, i_wdata     register address / BCD write data (captured)
//   i_ad_in             bus value read back from the chip
//   o_busy, o_done      transaction in progress / one-cycle end pulse
//   o_rdata             last data read from the bus
//   o_cs_n, o_rd_n,     chip select and strobes, active low
//   o_wr_n
//   o_ad_sel            0 = address phase, 1 = data phase
//   o_ad_out, o_ad_oe   bus drive value and tristate enable
//
// state      | meaning
// IDLE       | waiting for start, bus released
// ADDR_PULSE | cs_n/wr_n low, address on bus
// ADDR_HOLD  | strobes high, address still driven
// DATA_PULSE | cs_n low with wr_n (write) or rd_n (read)
// DATA_HOLD  | strobes high, write data still driven
// DONE       | done pulse, bus idle
module rtc_bus_sequencer #(
  parameter int unsigned T_PULSE = 8,
  parameter int unsigned T_HOLD  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_wr,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_ad_in,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_wr_n,
  output logic       o_ad_sel,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADDR_PULSE = 3'd1,
    S_ADDR_HOLD  = 3'd2,
    S_DATA_PULSE = 3'd3,
    S_DATA_HOLD  = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  // The counter holds "cycles remaining minus one" so a phase ends at zero.
  localparam logic [7:0] C_PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] C_HOLD_LD  = 8'(T_HOLD - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_wr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rdata;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_ad_sel;
  logic [7:0] r_ad_out;
  logic       r_ad_oe;

  // Outputs are registered, so each transition assigns the levels of the
  // state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'h00;
      r_wr     <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= 8'h00;
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_sel <= 1'b1;
      r_ad_out <= 8'h00;
      r_ad_oe  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_wr     <= i_wr;
            r_addr   <= i_addr;
            r_wdata  <= i_wdata;
            r_cnt    <= C_PULSE_LD;
            r_state  <= S_ADDR_PULSE;
            r_busy   <= 1'b1;
            r_cs_n   <= 1'b0;
            r_wr_n   <= 1'b0;   // address is always latched with wr_n
            r_rd_n   <= 1'b1;
            r_ad_sel <= 1'b0;
            r_ad_oe  <= 1'b1;
            r_ad_out <= i_addr;
          end
        end
        S_ADDR_PULSE: begin
          if (r_cnt == 8'h00) begin
            r_state <= S_ADDR_HOLD;
            r_cnt   <= C_HOLD_LD;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ADDR_HOLD: begin
          if (r_cnt == 8'h00) begin
            r_state  <= S_DATA_PULSE;
            r_cnt    <= C_PULSE_LD;
            r_cs_n   <= 1'b0;
            r_ad_sel <= 1'b1;
            if (r_wr) begin
              r_wr_n   <= 1'b0;
              r_ad_oe  <= 1'b1;
              r_ad_out <= r_wdata;
            end else begin
              r_rd_n   <= 1'b0;
              r_ad_oe  <= 1'b0;
              r_ad_out <= 8'h00;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DATA_PULSE: begin
          if (r_cnt == 8'h00) begin
            r_state <= S_DATA_HOLD;
            r_cnt   <= C_HOLD_LD;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            if (!r_wr) r_rdata <= i_ad_in;  // sampled while rd_n is still low
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DATA_HOLD: begin
          if (r_cnt == 8'h00) begin
            r_state  <= S_DONE;
            r_cnt    <= 8'h00;
            r_done   <= 1'b1;
            r_ad_sel <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_out <= 8'h00;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'h00;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= 8'h00;
          r_busy   <= 1'b0;
          r_cs_n   <= 1'b1;
          r_rd_n   <= 1'b1;
          r_wr_n   <= 1'b1;
          r_ad_sel <= 1'b1;
          r_ad_out <= 8'h00;
          r_ad_oe  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_rdata  = r_rdata;
  assign o_cs_n   = r_cs_n;
  assign o_rd_n   = r_rd_n;
  assign o_wr_n   = r_wr_n;
  assign o_ad_sel = r_ad_sel;
  assign o_ad_out = r_ad_out;
  assign o_ad_oe  = r_ad_oe;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer
// Directed bench for rtc_bus_sequencer: one instance with default timing and
// one with T_PULSE=1, T_HOLD=1. Expected bus levels come from the cycle
// schedule of a transaction, indexed by cycle number after the start edge.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       st0 = 1'b0;
  logic       st1 = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] ad_in = 8'h00;

  logic       busy0, done0, cs0, rdn0, wrn0, sel0, oe0;
  logic [7:0] rdata0, adout0;
  logic       busy1, done1, cs1, rdn1, wrn1, sel1, oe1;
  logic [7:0] rdata1, adout1;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] erd0 = 8'h00;
  logic [7:0] erd1 = 8'h00;

  rtc_bus_sequencer u_d0 (
    .clk(clk), .reset(reset), .i_start(st0), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_ad_in(ad_in), .o_busy(busy0), .o_done(done0),
    .o_rdata(rdata0), .o_cs_n(cs0), .o_rd_n(rdn0), .o_wr_n(wrn0),
    .o_ad_sel(sel0), .o_ad_out(adout0), .o_ad_oe(oe0)
  );

  rtc_bus_sequencer #(.T_PULSE(1), .T_HOLD(1)) u_d1 (
    .clk(clk), .reset(reset), .i_start(st1), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_ad_in(ad_in), .o_busy(busy1), .o_done(done1),
    .o_rdata(rdata1), .o_cs_n(cs1), .o_rd_n(rdn1), .o_wr_n(wrn1),
    .o_ad_sel(sel1), .o_ad_out(adout1), .o_ad_oe(oe1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, cs_n, rd_n, wr_n, ad_sel, ad_oe, ad_out, rdata}
  function automatic logic [22:0] obs_vec(input bit sel);
    if (sel) return {busy1, done1, cs1, rdn1, wrn1, sel1, oe1, adout1, rdata1};
    return {busy0, done0, cs0, rdn0, wrn0, sel0, oe0, adout0, rdata0};
  endfunction

  // Expected outputs in cycle k (cycle 1 follows the start edge); k outside
  // 1..2*tp+2*th+1 means idle.
  function automatic logic [22:0] exp_vec(input int k, input int tp, input int th,
                                          input logic w, input logic [7:0] a,
                                          input logic [7:0] wd, input logic [7:0] old_rd,
                                          input logic [7:0] new_rd);
    logic b = 1'b0, d = 1'b0, cs = 1'b1, rn = 1'b1, wn = 1'b1, s = 1'b1, oe = 1'b0;
    logic [7:0] o = 8'h00;
    logic [7:0] rd;
    int p1 = tp;
    int h1 = tp + th;
    int p2 = 2 * tp + th;
    int h2 = 2 * tp + 2 * th;
    rd = (!w && k > p2) ? new_rd : old_rd;
    if (k >= 1 && k <= p1) begin
      b = 1; cs = 0; wn = 0; s = 0; oe = 1; o = a;
    end else if (k > p1 && k <= h1) begin
      b = 1; s = 0; oe = 1; o = a;
    end else if (k > h1 && k <= p2) begin
      b = 1; cs = 0; s = 1;
      if (w) begin wn = 0; oe = 1; o = wd; end
      else rn = 0;
    end else if (k > p2 && k <= h2) begin
      b = 1; s = 1;
      if (w) begin oe = 1; o = wd; end
    end else if (k == h2 + 1) begin
      b = 1; d = 1;
    end
    return {b, d, cs, rn, wn, s, oe, o, rd};
  endfunction

  task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, expv);
    end
  endtask

  task automatic run(input string tag, input bit sel, input int tp, input int th,
                     input logic w, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] din, input bit spurious,
                     inout logic [7:0] rd_exp);
    int n = 2 * tp + 2 * th + 1;
    wr = w; addr = a; wdata = wd; ad_in = 8'hA5;
    if (sel) st1 = 1'b1; else st0 = 1'b1;
    tick();
    st0 = 1'b0; st1 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      ad_in = (k == 2 * tp + th) ? din : 8'hA5;
      chk($sformatf("%s_k%0d", tag, k), obs_vec(sel),
          exp_vec(k, tp, th, w, a, wd, rd_exp, din));
      if (spurious && (k == 5 || k == 20 || k == n)) begin
        st0 = 1'b1; wr = 1'b1; addr = 8'h41; wdata = 8'h99;
      end else begin
        st0 = 1'b0;
      end
      tick();
    end
    st0 = 1'b0; st1 = 1'b0;
    chk($sformatf("%s_idle", tag), obs_vec(sel),
        exp_vec(n + 1, tp, th, w, a, wd, rd_exp, din));
    if (!w) rd_exp = din;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_d0", obs_vec(0), exp_vec(0, 8, 4, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
    chk("reset_d1", obs_vec(1), exp_vec(0, 1, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
    reset = 1'b0;
    tick();

    run("wr21", 0, 8, 4, 1'b1, 8'h21, 8'h59, 8'h00, 1'b0, erd0);
    tick();
    run("rd23", 0, 8, 4, 1'b0, 8'h23, 8'h00, 8'h17, 1'b0, erd0);
    // back-to-back: start in the first IDLE cycle, rdata must stay 8'h17
    run("b2b_wr45", 0, 8, 4, 1'b1, 8'h45, 8'h12, 8'h00, 1'b0, erd0);
    tick();
    run("ignore", 0, 8, 4, 1'b1, 8'h21, 8'h59, 8'h00, 1'b1, erd0);
    tick();
    chk("not_queued", obs_vec(0), exp_vec(0, 8, 4, 1'b1, 8'h21, 8'h59, erd0, 8'h00));

    // Asynchronous reset in the middle of a read's data strobe
    wr = 1'b0; addr = 8'h23; st0 = 1'b1;
    tick();
    st0 = 1'b0;
    repeat (15) tick();
    chk("pre_reset_dpulse", obs_vec(0),
        exp_vec(16, 8, 4, 1'b0, 8'h23, 8'h00, erd0, 8'h00));
    #3 reset = 1'b1;
    #1;
    erd0 = 8'h00;
    chk("async_reset", obs_vec(0), exp_vec(0, 8, 4, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("after_reset_%0d", i), obs_vec(0),
          exp_vec(0, 8, 4, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
      tick();
    end
    run("rd30", 0, 8, 4, 1'b0, 8'h30, 8'h00, 8'h42, 1'b0, erd0);

    tick();
    run("p1_wr21", 1, 1, 1, 1'b1, 8'h21, 8'h59, 8'h00, 1'b0, erd1);
    run("p1_rd23", 1, 1, 1, 1'b0, 8'h23, 8'h00, 8'h17, 1'b0, erd1);
    tick();
    chk("p1_final", obs_vec(1), exp_vec(0, 1, 1, 1'b0, 8'h00, 8'h00, 8'h17, 8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
